mips_mc_ctrl: RTL and testbench
===============================

// Module: mips_mc_ctrl
// PURPOSE
//  Multicycle control FSM for the MIPS datapath (ifu/gpr/alu/dm). Decodes opcode/funct
//  held in IR; issues per-state enables/selects so one ALU and one memory port are reused
//  over FETCH..WB. Sits beside datapath inside mips; replaces single-cycle combinational ctrl.
// PARAMETERS
//  CNT_W      32  width of retired-instruction counter instr_cnt
//  MEM_TO     15  max dm_ack wait cycles before mem_err sets (0 = no timeout)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous reset, active-low (0 = reset)
//  op         in   6   IR[31:26]
//  funct      in   6   IR[5:0]
//  zero       in   1   ALU zero flag (combinational from datapath)
//  dm_ack     in   1   data memory done (read data valid / write committed)
//  pc_we      out  1   PC load enable
//  npc_sel    out  2   0 PC+4, 1 branch PC+4+(imm<<2), 2 jump {PC[31:28],idx,00}, 3 GPR[rs]
//  ir_we      out  1   IR load enable
//  gpr_we     out  1   register file write enable
//  reg_dst    out  2   0 rt, 1 rd, 2 $31
//  wd_sel     out  2   0 ALU result, 1 dm read data, 2 PC (link)
//  alu_src    out  1   0 GPR[rt], 1 extended imm
//  ext_op     out  2   0 zero-ext, 1 sign-ext, 2 imm<<16
//  alu_op     out  3   0 ADDU, 1 SUBU, 2 OR, 3 pass-B
//  dm_req     out  1   data memory request
//  dm_we      out  1   data memory write (valid only with dm_req)
//  illegal    out  1   sticky: undefined op/funct decoded
//  mem_err    out  1   sticky: dm_ack timeout
//  state      out  3   current FSM state (debug)
//  instr_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH, instr_cnt=0, illegal=0, mem_err=0, wait ctr=0;
//   all enables/req 0, all selects 0. Reset mid-instruction aborts; no partial write after.
//  States: FETCH=0 DECODE=1 EXE=2 MEMRD=3 MEMWR=4 WB=5. Outputs Moore except beq pc_we.
//  Decode set: R(op=000000) addu 100001, subu 100011, jr 001000; ori 001101; lui 001111;
//   lw 100011; sw 101011; beq 000100; j 000010; jal 000011. Anything else = illegal.
//  FETCH: ir_we=1, pc_we=1, npc_sel=0 -> DECODE.
//  DECODE: j: pc_we=1,npc_sel=2 -> FETCH. jal: pc_we=1,npc_sel=2,gpr_we=1,reg_dst=2,wd_sel=2
//   (PC already +4) -> FETCH. jr: pc_we=1,npc_sel=3 -> FETCH. illegal: set illegal -> FETCH
//   (treated as nop, not counted). others -> EXE.
//  EXE: addu alu_op0 src0; subu alu_op1 src0; ori alu_op2 src1 ext0; lui alu_op3 src1 ext2;
//   lw/sw alu_op0 src1 ext1. beq: alu_op1 src0 ext1, npc_sel=1, pc_we=zero -> FETCH.
//   lw -> MEMRD, sw -> MEMWR, else -> WB.
//  MEMRD/MEMWR: dm_req=1 (dm_we=1 in MEMWR), address held; stay until dm_ack=1.
//   MEMRD+ack -> WB; MEMWR+ack -> FETCH. dm_ack outside MEM states ignored.
//   Wait ctr counts non-ack cycles; on reaching MEM_TO set mem_err, drop req, -> FETCH (not counted).
//  WB: gpr_we=1; R: reg_dst=1 wd_sel=0; ori/lui: reg_dst=0 wd_sel=0; lw: reg_dst=0 wd_sel=1 -> FETCH.
//  Retire (instr_cnt+1) on the cycle leaving last state of a legal instr: DECODE(j/jal/jr),
//   EXE(beq), MEMWR+ack, WB. All-ones + 1 wraps to 0.
//  Latency (cycles): j/jal/jr 2; beq 3; R/ori/lui 4; sw 3+wait+1; lw 4+wait+1.
//  Write to $0 is issued normally; gpr suppresses it. illegal/mem_err cleared only by reset.
// TESTING
//  T1 reset: rst=0 async mid-EXE -> state=0, all enables 0, instr_cnt=0 same cycle.
//  T2 addu $3,$1,$2 ($1=5,$2=7): states 0,1,2,5; gpr_we only in WB, reg_dst=1; $3=12; cnt=1.
//  T3 lw, dm_ack after 3 wait cycles: dm_req high 4 cycles, dm_we=0, WB wd_sel=1; 8 cycles total.
//  T4 beq zero=1 then zero=0: pc_we=1/npc_sel=1 in EXE first case, pc_we=0 second; 3 cycles each.
//  T5 jal: DECODE gpr_we=1 reg_dst=2 wd_sel=2 pc_we=1 npc_sel=2; $31=PC+4; 2 cycles.
//  T6 op=111111 -> illegal=1 stays, cnt unchanged; MEM_TO=15 no ack -> mem_err=1 after 15 cycles.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multicycle control unit for the MIPS datapath: decodes op/funct held in IR and
// sequences FETCH..WB so a single ALU and a single memory port are shared.
//
//  state  | meaning
//  FETCH  | load IR, PC <= PC+4
//  DECODE | IR valid; jumps finish here, illegal ops are dropped
//  EXE    | ALU operation; beq resolves the branch here
//  MEMRD  | dm read request held until dm_ack or timeout
//  MEMWR  | dm write request held until dm_ack or timeout
//  WB     | register file write-back
module mips_mc_ctrl #(
    parameter int CNT_W  = 32,
    parameter int MEM_TO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_ack,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             ir_we,
    output logic             gpr_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src,
    output logic [1:0]       ext_op,
    output logic [2:0]       alu_op,
    output logic             dm_req,
    output logic             dm_we,
    output logic             illegal,
    output logic             mem_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWR  = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam int WAIT_W = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;

    state_t            st;
    state_t            st_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              timeout;
    logic              retire;
    logic              set_ill;
    logic              set_merr;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, legal;
    logic [2:0] alu_op_d;
    logic       alu_src_d;
    logic [1:0] ext_op_d;

    assign is_r    = (op == 6'b000000);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_jr   = is_r && (funct == 6'b001000);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign legal   = is_addu | is_subu | is_jr | is_ori | is_lui |
                     is_lw | is_sw | is_beq | is_j | is_jal;

    assign timeout = (MEM_TO != 0) && (wait_cnt == WAIT_W'(MEM_TO - 1));
    assign state   = st;

    always_comb begin
        alu_op_d  = 3'd0;
        alu_src_d = 1'b0;
        ext_op_d  = 2'd0;
        if (is_subu) begin
            alu_op_d = 3'd1;
        end else if (is_ori) begin
            alu_op_d  = 3'd2;
            alu_src_d = 1'b1;
        end else if (is_lui) begin
            alu_op_d  = 3'd3;
            alu_src_d = 1'b1;
            ext_op_d  = 2'd2;
        end else if (is_lw || is_sw) begin
            alu_src_d = 1'b1;
            ext_op_d  = 2'd1;
        end else if (is_beq) begin
            alu_op_d = 3'd1;
            ext_op_d = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= S_FETCH;
        end else begin
            st <= st_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt <= '0;
            illegal   <= 1'b0;
            mem_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
            if (set_ill) illegal <= 1'b1;
            if (set_merr) mem_err <= 1'b1;
            wait_cnt <= mem_wait ? wait_cnt + WAIT_W'(1) : '0;
        end
    end

    // Everything is forced low while rst is asserted so an aborted instruction
    // cannot leave a write enable or memory request active.
    always_comb begin
        st_nxt   = st;
        pc_we    = 1'b0;
        npc_sel  = 2'd0;
        ir_we    = 1'b0;
        gpr_we   = 1'b0;
        reg_dst  = 2'd0;
        wd_sel   = 2'd0;
        alu_src  = 1'b0;
        ext_op   = 2'd0;
        alu_op   = 3'd0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        retire   = 1'b0;
        set_ill  = 1'b0;
        set_merr = 1'b0;
        mem_wait = 1'b0;
        if (rst) begin
            case (st)
                S_FETCH: begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    st_nxt = S_DECODE;
                end
                S_DECODE: begin
                    if (!legal) begin
                        set_ill = 1'b1;
                        st_nxt  = S_FETCH;
                    end else if (is_j || is_jal) begin
                        pc_we   = 1'b1;
                        npc_sel = 2'd2;
                        if (is_jal) begin
                            gpr_we  = 1'b1;
                            reg_dst = 2'd2;
                            wd_sel  = 2'd2;
                        end
                        retire = 1'b1;
                        st_nxt = S_FETCH;
                    end else if (is_jr) begin
                        pc_we   = 1'b1;
                        npc_sel = 2'd3;
                        retire  = 1'b1;
                        st_nxt  = S_FETCH;
                    end else begin
                        st_nxt = S_EXE;
                    end
                end
                S_EXE: begin
                    alu_op  = alu_op_d;
                    alu_src = alu_src_d;
                    ext_op  = ext_op_d;
                    if (is_beq) begin
                        npc_sel = 2'd1;
                        pc_we   = zero;
                        retire  = 1'b1;
                        st_nxt  = S_FETCH;
                    end else if (is_lw) begin
                        st_nxt = S_MEMRD;
                    end else if (is_sw) begin
                        st_nxt = S_MEMWR;
                    end else begin
                        st_nxt = S_WB;
                    end
                end
                S_MEMRD, S_MEMWR: begin
                    // Address operands stay selected for the whole request.
                    alu_op  = alu_op_d;
                    alu_src = alu_src_d;
                    ext_op  = ext_op_d;
                    dm_req  = 1'b1;
                    dm_we   = (st == S_MEMWR);
                    if (dm_ack) begin
                        if (st == S_MEMRD) begin
                            st_nxt = S_WB;
                        end else begin
                            retire = 1'b1;
                            st_nxt = S_FETCH;
                        end
                    end else if (timeout) begin
                        set_merr = 1'b1;
                        st_nxt   = S_FETCH;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                S_WB: begin
                    alu_op  = alu_op_d;
                    alu_src = alu_src_d;
                    ext_op  = ext_op_d;
                    gpr_we  = 1'b1;
                    reg_dst = is_r ? 2'd1 : 2'd0;
                    wd_sel  = is_lw ? 2'd1 : 2'd0;
                    retire  = 1'b1;
                    st_nxt  = S_FETCH;
                end
                default: st_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed scenarios then random instruction streams, each
// checked cycle by cycle against an instruction-level sequence model.
module tb_mips_mc_ctrl;

    localparam int CNT_W  = 4;
    localparam int MEM_TO = 15;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
    localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXE = 3'd2;
    localparam logic [2:0] ST_MEMRD = 3'd3, ST_MEMWR = 3'd4, ST_WB = 3'd5;

    logic             clk, rst;
    logic [5:0]       op, funct;
    logic             zero, dm_ack;
    logic             pc_we, ir_we, gpr_we, alu_src, dm_req, dm_we, illegal, mem_err;
    logic [1:0]       npc_sel, reg_dst, wd_sel, ext_op;
    logic [2:0]       alu_op, state;
    logic [CNT_W-1:0] instr_cnt;

    mips_mc_ctrl #(.CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .dm_ack(dm_ack),
        .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .gpr_we(gpr_we),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op),
        .alu_op(alu_op), .dm_req(dm_req), .dm_we(dm_we), .illegal(illegal),
        .mem_err(mem_err), .state(state), .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ack;
        logic       zero;
        logic       pc_we;
        logic [1:0] npc_sel;
        logic       ir_we;
        logic       gpr_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [2:0] alu_op;
        logic       dm_req;
        logic       dm_we;
    } cyc_t;

    cyc_t             exp_q[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    int               instr_no = 0;
    int               cyc_no   = 0;
    int               nreq;
    logic             pl_retire, pl_ill, pl_merr;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ill, exp_merr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (instr %0d cycle %0d): observed %0h expected %0h",
                   tag, instr_no, cyc_no, obs, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c      = '0;
        c.st   = st;
        c.ack  = 1'($urandom_range(0, 1));
        c.zero = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Expected cycle sequence of one instruction from FETCH up to its last state.
    task automatic plan(input int kind, input int waits, input logic zv);
        cyc_t c;
        int   n;
        exp_q.delete();
        pl_retire = 1'b0;
        pl_ill    = 1'b0;
        pl_merr   = 1'b0;
        c = blank(ST_FETCH);
        c.ir_we = 1'b1;
        c.pc_we = 1'b1;
        exp_q.push_back(c);
        c = blank(ST_DECODE);
        if (kind == K_J || kind == K_JAL || kind == K_JR) begin
            c.pc_we   = 1'b1;
            c.npc_sel = (kind == K_JR) ? 2'd3 : 2'd2;
            if (kind == K_JAL) begin
                c.gpr_we  = 1'b1;
                c.reg_dst = 2'd2;
                c.wd_sel  = 2'd2;
            end
            exp_q.push_back(c);
            pl_retire = 1'b1;
            return;
        end
        exp_q.push_back(c);
        if (kind == K_ILL) begin
            pl_ill = 1'b1;
            return;
        end
        c = blank(ST_EXE);
        case (kind)
            K_SUBU:      c.alu_op = 3'd1;
            K_ORI:       begin c.alu_op = 3'd2; c.alu_src = 1'b1; end
            K_LUI:       begin c.alu_op = 3'd3; c.alu_src = 1'b1; c.ext_op = 2'd2; end
            K_LW, K_SW:  begin c.alu_src = 1'b1; c.ext_op = 2'd1; end
            K_BEQ:       begin c.alu_op = 3'd1; c.ext_op = 2'd1; end
            default:     ;
        endcase
        if (kind == K_BEQ) begin
            c.zero    = zv;
            c.npc_sel = 2'd1;
            c.pc_we   = zv;
            exp_q.push_back(c);
            pl_retire = 1'b1;
            return;
        end
        exp_q.push_back(c);
        if (kind == K_LW || kind == K_SW) begin
            n = (waits >= MEM_TO) ? MEM_TO : waits + 1;
            for (int i = 0; i < n; i++) begin
                c = blank((kind == K_LW) ? ST_MEMRD : ST_MEMWR);
                c.dm_req = 1'b1;
                c.dm_we  = (kind == K_SW);
                c.ack    = (i == waits);
                exp_q.push_back(c);
            end
            if (waits >= MEM_TO) begin
                pl_merr = 1'b1;
                return;
            end
            if (kind == K_SW) begin
                pl_retire = 1'b1;
                return;
            end
        end
        c = blank(ST_WB);
        c.gpr_we  = 1'b1;
        c.reg_dst = (kind == K_ADDU || kind == K_SUBU) ? 2'd1 : 2'd0;
        c.wd_sel  = (kind == K_LW) ? 2'd1 : 2'd0;
        exp_q.push_back(c);
        pl_retire = 1'b1;
    endtask

    task automatic set_ir(input int kind);
        funct = 6'($urandom);
        case (kind)
            K_ADDU: begin op = 6'b000000; funct = 6'b100001; end
            K_SUBU: begin op = 6'b000000; funct = 6'b100011; end
            K_JR:   begin op = 6'b000000; funct = 6'b001000; end
            K_ORI:  op = 6'b001101;
            K_LUI:  op = 6'b001111;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_JAL:  op = 6'b000011;
            default: begin
                case ($urandom_range(0, 3))
                    0: op = 6'b111111;
                    1: op = 6'b001000;
                    2: op = 6'b100000;
                    default: begin op = 6'b000000; funct = 6'b100000; end
                endcase
            end
        endcase
    endtask

    task automatic run_instr(input int kind, input int waits, input logic zv);
        cyc_t c;
        plan(kind, waits, zv);
        instr_no++;
        nreq = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            c = exp_q[i];
            cyc_no = i;
            @(negedge clk);
            if (i == 0) set_ir(kind);
            zero   = c.zero;
            dm_ack = c.ack;
            #1;
            chk("state", 32'(state), 32'(c.st));
            chk("pc_we", 32'(pc_we), 32'(c.pc_we));
            chk("npc_sel", 32'(npc_sel), 32'(c.npc_sel));
            chk("ir_we", 32'(ir_we), 32'(c.ir_we));
            chk("gpr_we", 32'(gpr_we), 32'(c.gpr_we));
            chk("reg_dst", 32'(reg_dst), 32'(c.reg_dst));
            chk("wd_sel", 32'(wd_sel), 32'(c.wd_sel));
            chk("dm_req", 32'(dm_req), 32'(c.dm_req));
            chk("dm_we", 32'(dm_we), 32'(c.dm_we));
            chk("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
            chk("illegal", 32'(illegal), 32'(exp_ill));
            chk("mem_err", 32'(mem_err), 32'(exp_merr));
            if (c.st == ST_EXE) begin
                chk("alu_op", 32'(alu_op), 32'(c.alu_op));
                chk("alu_src", 32'(alu_src), 32'(c.alu_src));
                chk("ext_op", 32'(ext_op), 32'(c.ext_op));
            end
            if (dm_req === 1'b1) nreq++;
        end
        if (pl_retire) exp_cnt = exp_cnt + 1'b1;
        if (pl_ill) exp_ill = 1'b1;
        if (pl_merr) exp_merr = 1'b1;
    endtask

    initial begin
        int kind, waits;
        rst      = 1'b0;
        op       = 6'd0;
        funct    = 6'd0;
        zero     = 1'b0;
        dm_ack   = 1'b0;
        exp_cnt  = '0;
        exp_ill  = 1'b0;
        exp_merr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'(ST_FETCH));
        chk("rst_ir_we", 32'(ir_we), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        run_instr(K_ADDU, 0, 1'b0);
        run_instr(K_LW, 3, 1'b0);
        chk("t3_req_cycles", 32'(nreq), 32'd4);
        run_instr(K_BEQ, 0, 1'b1);
        run_instr(K_BEQ, 0, 1'b0);
        run_instr(K_JAL, 0, 1'b0);
        run_instr(K_J, 0, 1'b0);
        run_instr(K_JR, 0, 1'b0);
        run_instr(K_SUBU, 0, 1'b0);
        run_instr(K_ORI, 0, 1'b0);
        run_instr(K_LUI, 0, 1'b0);
        run_instr(K_SW, 0, 1'b0);
        run_instr(K_SW, 14, 1'b0);
        run_instr(K_LW, 14, 1'b0);
        run_instr(K_ILL, 0, 1'b0);
        run_instr(K_ADDU, 0, 1'b0);
        run_instr(K_LW, 15, 1'b0);
        chk("t6_req_cycles", 32'(nreq), 32'(MEM_TO));
        run_instr(K_SW, 20, 1'b0);
        run_instr(K_ADDU, 0, 1'b0);

        // Asynchronous reset in the middle of EXE
        @(negedge clk);
        op = 6'b000000;
        funct = 6'b100001;
        @(negedge clk);
        @(negedge clk);
        #1 chk("t1_pre_state", 32'(state), 32'(ST_EXE));
        #1 rst = 1'b0;
        #1;
        chk("t1_state", 32'(state), 32'(ST_FETCH));
        chk("t1_pc_we", 32'(pc_we), 32'd0);
        chk("t1_ir_we", 32'(ir_we), 32'd0);
        chk("t1_gpr_we", 32'(gpr_we), 32'd0);
        chk("t1_dm_req", 32'(dm_req), 32'd0);
        chk("t1_dm_we", 32'(dm_we), 32'd0);
        chk("t1_npc_sel", 32'(npc_sel), 32'd0);
        chk("t1_cnt", 32'(instr_cnt), 32'd0);
        chk("t1_illegal", 32'(illegal), 32'd0);
        chk("t1_mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_cnt  = '0;
        exp_ill  = 1'b0;
        exp_merr = 1'b0;

        for (int n = 0; n < 200; n++) begin
            kind  = $urandom_range(0, 10);
            waits = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 4);
            run_instr(kind, waits, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
